am2910_seq_ctrl: RTL and testbench
==================================

# am2910_seq_ctrl

Next-address sequencing controller for the AM2910-style microprogram sequencer. Decodes the 4-bit microinstruction opcode together with the condition input, drives push/pop/clear on the 5-deep 12-bit subroutine stack, and owns the microprogram counter (uPC) and the 12-bit register/counter (R). It selects the next address Y from D, uPC, R or the stack top F. It sits between the microcode pipeline register and the stack, and is instantiated beside the stack in the sequencer top level.

## Interface
Parameters:
- AW, 12, address / counter width (stack width matches)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  4  opcode, 0..15 (see Operation)
- cc_n  in  1  condition code, active low
- ccen_n  in  1  condition enable, active low; high forces pass
- rld_n  in  1  active low; loads R from D unconditionally
- ci  in  1  uPC increment carry-in
- d  in  AW  direct/branch address and R load data
- stk_top  in  AW  stack data_out (F); reads 0 when the stack is empty
- stk_full  in  1  stack full flag
- stk_empty  in  1  stack empty flag
- y  out  AW  next microaddress
- stk_push  out  1  stack push_en
- stk_pop  out  1  stack pop_en
- stk_clear  out  1  stack clear_en
- stk_data  out  AW  stack data_in, always equal to the current uPC
- pl_n  out  1  pipeline-register D-source enable
- map_n  out  1  mapping-PROM D-source enable
- vect_n  out  1  vector D-source enable
- full_n  out  1  equals ~stk_full

## Operation
- pass = ccen_n | ~cc_n. rz = (R == 0).
- Opcodes give the Y source and side effects. Each line lists the pass case, then the fail case.
  - 0 JZ: Y=0, clear.
  - 1 CJS: D and push / uPC.
  - 2 JMAP: D.
  - 3 CJP: D / uPC.
  - 4 PUSH: uPC and push; pass also loads R←D.
  - 5 JSRP: D and push / R and push.
  - 6 CJV: D / uPC.
  - 7 JRP: D / R.
  - 8 RFCT: if !rz then Y=F and R−1; if rz then Y=uPC and pop.
  - 9 RPCT: if !rz then Y=D and R−1; if rz then Y=uPC.
  - 10 CRTN: F and pop / uPC.
  - 11 CJPP: D and pop / uPC.
  - 12 LDCT: Y=uPC, R←D.
  - 13 LOOP: uPC and pop / F.
  - 14 CONT: uPC.
  - 15 TWB: pass gives uPC and pop. Fail with !rz gives F and R−1. Fail with rz gives D and pop.
- map_n is low only for opcode 2. vect_n is low only for opcode 6. pl_n is low for every other opcode.
- uPC ← y + ci, modulo 2^AW. y=0xFFF with ci=1 gives uPC=0x000.
- R priority: rld_n=0 load, then opcode load, then decrement, then hold. R decrements only when R≠0, so it never wraps below 0.
- stk_push is asserted even when stk_full=1. The stack drops the push, and the controller does not stall. full_n reports the condition.
- A pop with stk_empty=1 is harmless, and F reads 0.
- Reset: uPC=0 and R=0. While reset=1: y=0, stk_clear=1, stk_push=stk_pop=0, pl_n=0, map_n=vect_n=1. A reset in mid-loop discards R and uPC at the next edge.

## Timing
- y, stk_*, pl_n, map_n and vect_n are combinational from instr, cc_n, ccen_n, d, stk_top, and the registered uPC and R. No added latency.
- uPC and R update on the rising clk after the decode cycle.
- A push in cycle n writes the cycle-n uPC. From cycle n+1, F equals that value.
- A pop in cycle n makes the new top visible in cycle n+1.
- stk_clear is driven for a single cycle on JZ. The stack is empty from the next cycle.

## Structure
- Package am2910_pkg holds:
  - AW
  - the opcode enum (JZ..TWB, values 0..15)
  - the Y-source select enum (SEL_D, SEL_UPC, SEL_R, SEL_F, SEL_ZERO)
- Sub-module am2910_regcnt: the R register with load, decrement, zero-detect (rz) and synchronous reset.
- The controller contains: the decode (case on opcode), the Y mux, and the uPC register with incrementer.

## Test plan
- Reset: assert reset for 2 cycles with instr=CONT. Required: y=0 and stk_clear=1 while reset is high. After release, with ci=1, y goes 0x000, 0x001, 0x002.
- CJS then CRTN: uPC=0x010, CJS with cc_n=0 and d=0x200, giving y=0x200 and push of 0x010. Then CONT ×2. Then CRTN with pass, giving y=0x010 and pop, and stk_empty=1 on the next cycle.
- LDCT then RPCT: LDCT with d=3 and R=3. RPCT with d=0x050 gives y=0x050 for 3 cycles while R goes 3→2→1→0. The 4th RPCT gives y=uPC.
- Stack full: 6 consecutive PUSH. Required: stk_full=1 and full_n=0 after the 5th. The 6th push is dropped, and F still holds the 5th pushed uPC.
- TWB, all four pass/rz combinations: check the Y source, the pop, and the R decrement for each.
- rld_n vs decrement: rld_n=0 with d=0x0AA during RFCT with R=5. Required: R=0x0AA next cycle, and Y=F this cycle.

Source files
------------

// File: rtl/am2910_pkg.sv
// am2910_pkg: shared width, opcode and Y-source definitions for the AM2910-style sequencer.
package am2910_pkg;
    localparam int AW = 12;
    typedef enum logic [3:0] {
        JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
        RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
    } opcode_e;
    typedef enum logic [2:0] {SEL_D, SEL_UPC, SEL_R, SEL_F, SEL_ZERO} ysel_e;
endpackage

// File: rtl/am2910_regcnt.sv
// am2910_regcnt: loop register/counter R with load, saturating decrement and zero detect.
module am2910_regcnt #(
    parameter int W = am2910_pkg::AW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic         dec_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] r_o,
    output logic         rz_o
);
    import am2910_pkg::*;
    logic [W-1:0] r_q, r_d;
    assign rz_o = (r_q == '0);
    assign r_o  = r_q;
    always_comb r_d = ld_i ? d_i : (dec_i && !rz_o) ? r_q - W'(1) : r_q;
    always_ff @(posedge clk) r_q <= reset ? '0 : r_d;
endmodule

// File: rtl/am2910_seq_ctrl.sv
// am2910_seq_ctrl: opcode decode, next-address mux, uPC and stack control for the sequencer.
module am2910_seq_ctrl #(
    parameter int AW = am2910_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    instr,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic          rld_n,
    input  logic          ci,
    input  logic [AW-1:0] d,
    input  logic [AW-1:0] stk_top,
    input  logic          stk_full,
    input  logic          stk_empty,
    output logic [AW-1:0] y,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_clear,
    output logic [AW-1:0] stk_data,
    output logic          pl_n,
    output logic          map_n,
    output logic          vect_n,
    output logic          full_n
);
    import am2910_pkg::*;
    opcode_e      op;
    ysel_e        sel;
    logic         pass, rz, push, pop, clr, ld_op, dec;
    logic [AW-1:0] r_q, upc_q, upc_d, y_mux;
    // An empty-stack pop is harmless (F reads 0), so the flag needs no decode.
    logic         unused_stk_empty;
    assign unused_stk_empty = stk_empty;
    assign op   = opcode_e'(instr);
    assign pass = ccen_n | ~cc_n;
    always_comb begin
        sel   = SEL_UPC;
        push  = 1'b0;
        pop   = 1'b0;
        clr   = 1'b0;
        ld_op = 1'b0;
        dec   = 1'b0;
        case (op)
            JZ:       begin sel = SEL_ZERO; clr = 1'b1; end
            CJS:      begin sel = pass ? SEL_D : SEL_UPC; push = pass; end
            JMAP:     sel = SEL_D;
            CJP, CJV: sel = pass ? SEL_D : SEL_UPC;
            PUSH:     begin push = 1'b1; ld_op = pass; end
            JSRP:     begin sel = pass ? SEL_D : SEL_R; push = 1'b1; end
            JRP:      sel = pass ? SEL_D : SEL_R;
            RFCT:     begin sel = rz ? SEL_UPC : SEL_F; dec = !rz; pop = rz; end
            RPCT:     begin sel = rz ? SEL_UPC : SEL_D; dec = !rz; end
            CRTN:     begin sel = pass ? SEL_F : SEL_UPC; pop = pass; end
            CJPP:     begin sel = pass ? SEL_D : SEL_UPC; pop = pass; end
            LDCT:     ld_op = 1'b1;
            LOOP:     begin sel = pass ? SEL_UPC : SEL_F; pop = pass; end
            TWB:      begin
                sel = pass ? SEL_UPC : (rz ? SEL_D : SEL_F);
                pop = pass | rz;
                dec = !pass && !rz;
            end
            default:  ;
        endcase
    end
    always_comb y_mux = (sel == SEL_D)    ? d       :
                        (sel == SEL_R)    ? r_q     :
                        (sel == SEL_F)    ? stk_top :
                        (sel == SEL_ZERO) ? '0      : upc_q;
    // Reset overrides every decoded output so the stack is cleared while held.
    assign y         = reset ? '0 : y_mux;
    assign stk_push  = push & ~reset;
    assign stk_pop   = pop & ~reset;
    assign stk_clear = clr | reset;
    assign stk_data  = upc_q;
    assign map_n     = reset | (op != JMAP);
    assign vect_n    = reset | (op != CJV);
    assign pl_n      = ~reset & ((op == JMAP) | (op == CJV));
    assign full_n    = ~stk_full;
    assign upc_d     = y + AW'(ci);
    always_ff @(posedge clk) upc_q <= reset ? '0 : upc_d;
    am2910_regcnt #(.W(AW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .ld_i  (~rld_n | ld_op),
        .dec_i (dec),
        .d_i   (d),
        .r_o   (r_q),
        .rz_o  (rz)
    );
endmodule

// File: tb/tb_am2910_seq_ctrl.sv
// tb_am2910_seq_ctrl: directed vector table plus multi-cycle sequences against a 5-deep stack model.
module tb_am2910_seq_ctrl;
    import am2910_pkg::*;
    logic        clk = 1'b0;
    logic        reset, cc_n, ccen_n, rld_n, ci;
    logic [3:0]  instr;
    logic [11:0] d, stk_top, y, stk_data;
    logic        stk_full, stk_empty, stk_push, stk_pop, stk_clear, pl_n, map_n, vect_n, full_n;
    logic [5:0]  flg;
    logic [11:0] stk [5];
    logic [2:0]  sp = 3'd0;
    int          n_cmp = 0, n_bad = 0;
    typedef struct {
        logic [3:0]  op;
        logic        cc, ccen, ci;
        logic [11:0] d, y;
        logic [5:0]  f;
    } vec_t;
    vec_t tbl[$];

    am2910_seq_ctrl #(.AW(12)) dut (
        .clk(clk), .reset(reset), .instr(instr), .cc_n(cc_n), .ccen_n(ccen_n),
        .rld_n(rld_n), .ci(ci), .d(d), .stk_top(stk_top), .stk_full(stk_full),
        .stk_empty(stk_empty), .y(y), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_clear(stk_clear), .stk_data(stk_data), .pl_n(pl_n), .map_n(map_n),
        .vect_n(vect_n), .full_n(full_n)
    );

    always #5 clk = ~clk;
    assign flg       = {stk_push, stk_pop, stk_clear, pl_n, map_n, vect_n};
    assign stk_full  = (sp == 3'd5);
    assign stk_empty = (sp == 3'd0);
    assign stk_top   = stk_empty ? 12'h000 : stk[sp - 3'd1];

    always @(posedge clk) begin
        if (stk_clear) sp <= 3'd0;
        else if (stk_push && !stk_full) begin
            stk[sp] <= stk_data;
            sp <= sp + 3'd1;
        end else if (stk_pop && !stk_empty) sp <= sp - 3'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set(input logic [3:0] op, input logic cc, input logic ccen, input logic [11:0] dd);
        instr = op; cc_n = cc; ccen_n = ccen; d = dd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t v(input logic [3:0] op, input logic cc, input logic ccen, input logic c,
                               input logic [11:0] dd, input logic [11:0] yy, input logic [5:0] ff);
        vec_t t;
        t.op = op; t.cc = cc; t.ccen = ccen; t.ci = c; t.d = dd; t.y = yy; t.f = ff;
        return t;
    endfunction

    initial begin
        reset = 1'b1; rld_n = 1'b1; ci = 1'b1;
        set(CONT, 1, 1, 12'h000);
        @(negedge clk);
        // reset: outputs forced, even with a pushing opcode
        for (int i = 0; i < 2; i++) begin
            set(CONT, 1, 1, 12'h000);
            chk("rst_y", y, 0);
            chk("rst_flags", flg, 6'b001011);
            tick;
        end
        set(CJS, 0, 0, 12'h222);
        chk("rst_cjs_y", y, 0);
        chk("rst_cjs_flags", flg, 6'b001011);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set(CONT, 1, 1, 12'h000);
            chk($sformatf("post_rst_y%0d", i), y, i);
            tick;
        end
        // table: state starts at uPC=0, R=0, empty stack
        reset = 1'b1; tick; reset = 1'b0;
        tbl.push_back(v(CONT, 0, 0, 1, 12'h123, 12'h000, 6'b000011));
        tbl.push_back(v(JMAP, 0, 0, 1, 12'h040, 12'h040, 6'b000101));
        tbl.push_back(v(CJV,  0, 0, 1, 12'h080, 12'h080, 6'b000110));
        tbl.push_back(v(CJV,  1, 0, 1, 12'h0F0, 12'h081, 6'b000110));
        tbl.push_back(v(CJP,  1, 1, 1, 12'h100, 12'h100, 6'b000011));
        tbl.push_back(v(CJP,  1, 0, 1, 12'h200, 12'h101, 6'b000011));
        tbl.push_back(v(JRP,  1, 0, 1, 12'h300, 12'h000, 6'b000011));
        tbl.push_back(v(LDCT, 0, 0, 1, 12'h007, 12'h001, 6'b000011));
        tbl.push_back(v(JRP,  1, 0, 1, 12'h300, 12'h007, 6'b000011));
        tbl.push_back(v(JSRP, 1, 0, 1, 12'h300, 12'h007, 6'b100011));
        tbl.push_back(v(CJS,  1, 0, 1, 12'h400, 12'h008, 6'b000011));
        tbl.push_back(v(CJPP, 0, 0, 1, 12'h500, 12'h500, 6'b010011));
        tbl.push_back(v(JZ,   0, 0, 1, 12'h777, 12'h000, 6'b001011));
        tbl.push_back(v(LOOP, 1, 0, 1, 12'h000, 12'h000, 6'b000011));
        tbl.push_back(v(PUSH, 0, 0, 1, 12'h033, 12'h001, 6'b100011));
        tbl.push_back(v(JRP,  1, 0, 1, 12'h000, 12'h033, 6'b000011));
        tbl.push_back(v(RFCT, 0, 0, 1, 12'h000, 12'h001, 6'b000011));
        tbl.push_back(v(LOOP, 0, 0, 1, 12'h000, 12'h002, 6'b010011));
        tbl.push_back(v(CONT, 0, 0, 0, 12'h000, 12'h003, 6'b000011));
        tbl.push_back(v(CONT, 0, 0, 1, 12'h000, 12'h003, 6'b000011));
        tbl.push_back(v(CJP,  0, 0, 1, 12'hFFF, 12'hFFF, 6'b000011));
        tbl.push_back(v(CONT, 0, 0, 1, 12'h000, 12'h000, 6'b000011));
        tbl.push_back(v(LDCT, 0, 0, 1, 12'h000, 12'h001, 6'b000011));
        tbl.push_back(v(RFCT, 0, 0, 1, 12'h000, 12'h002, 6'b010011));
        foreach (tbl[i]) begin
            ci = tbl[i].ci;
            set(tbl[i].op, tbl[i].cc, tbl[i].ccen, tbl[i].d);
            chk($sformatf("vec%0d_y", i), y, tbl[i].y);
            chk($sformatf("vec%0d_flags", i), flg, tbl[i].f);
            tick;
        end
        ci = 1'b1;
        // CJS then CRTN
        set(JZ, 0, 0, 12'h000); tick;
        set(CJP, 0, 0, 12'h00F); tick;
        set(CJS, 0, 0, 12'h200);
        chk("cjs_y", y, 12'h200);
        chk("cjs_push", stk_push, 1);
        chk("cjs_data", stk_data, 12'h010);
        tick;
        set(CONT, 0, 0, 12'h000);
        chk("cont1_y", y, 12'h201);
        chk("cjs_top", stk_top, 12'h010);
        tick;
        set(CONT, 0, 0, 12'h000);
        chk("cont2_y", y, 12'h202);
        tick;
        set(CRTN, 0, 0, 12'h000);
        chk("crtn_y", y, 12'h010);
        chk("crtn_pop", stk_pop, 1);
        tick;
        chk("crtn_empty", stk_empty, 1);
        set(CONT, 0, 0, 12'h000);
        chk("after_crtn_y", y, 12'h011);
        tick;
        // LDCT then RPCT countdown
        set(LDCT, 0, 0, 12'h003); tick;
        chk("ldct_r", dut.r_q, 3);
        for (int k = 0; k < 3; k++) begin
            set(RPCT, 0, 0, 12'h050);
            chk($sformatf("rpct%0d_y", k), y, 12'h050);
            tick;
            chk($sformatf("rpct%0d_r", k), dut.r_q, 2 - k);
        end
        set(RPCT, 0, 0, 12'h050);
        chk("rpct_exit_y", y, 12'h051);
        tick;
        chk("rpct_exit_r", dut.r_q, 0);
        // reset in mid-loop
        set(LDCT, 0, 0, 12'h005); tick;
        set(RFCT, 0, 0, 12'h000); tick;
        reset = 1'b1; tick; reset = 1'b0;
        chk("midloop_rst_r", dut.r_q, 0);
        chk("midloop_rst_upc", dut.upc_q, 0);
        // stack full
        set(JZ, 0, 0, 12'h000); tick;
        for (int k = 1; k <= 6; k++) begin
            set(PUSH, 1, 0, 12'h000);
            chk($sformatf("push%0d_en", k), stk_push, 1);
            chk($sformatf("push%0d_data", k), stk_data, k);
            tick;
            if (k == 4) chk("full_n_at4", full_n, 1);
            if (k == 5) chk("full_n_at5", full_n, 0);
        end
        chk("full_top", stk_top, 12'h005);
        // TWB: fail/!rz, pass/!rz, pass/rz, fail/rz
        set(JZ, 0, 0, 12'h000); tick;
        set(LDCT, 0, 0, 12'h002); tick;
        set(PUSH, 1, 0, 12'h000); tick;
        set(TWB, 1, 0, 12'h0D0);
        chk("twb_fnz_y", y, 12'h002);
        chk("twb_fnz_flags", flg, 6'b000011);
        tick;
        chk("twb_fnz_r", dut.r_q, 1);
        set(TWB, 0, 0, 12'h0D0);
        chk("twb_pnz_y", y, 12'h003);
        chk("twb_pnz_flags", flg, 6'b010011);
        tick;
        chk("twb_pnz_r", dut.r_q, 1);
        set(PUSH, 1, 0, 12'h000); tick;
        set(LDCT, 0, 0, 12'h000); tick;
        set(TWB, 0, 0, 12'h0D0);
        chk("twb_pz_y", y, 12'h006);
        chk("twb_pz_flags", flg, 6'b010011);
        tick;
        chk("twb_pz_r", dut.r_q, 0);
        set(PUSH, 1, 0, 12'h000); tick;
        set(TWB, 1, 0, 12'h0D0);
        chk("twb_fz_y", y, 12'h0D0);
        chk("twb_fz_flags", flg, 6'b010011);
        tick;
        chk("twb_fz_r", dut.r_q, 0);
        // rld_n beats decrement
        set(JZ, 0, 0, 12'h000); tick;
        set(PUSH, 1, 0, 12'h000); tick;
        set(LDCT, 0, 0, 12'h005); tick;
        rld_n = 1'b0;
        set(RFCT, 0, 0, 12'h0AA);
        chk("rld_rfct_y", y, 12'h001);
        chk("rld_rfct_flags", flg, 6'b000011);
        tick;
        rld_n = 1'b1;
        chk("rld_r", dut.r_q, 12'h0AA);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
